// File: rtl/microwave_pkg.sv
// Shared constants and state encoding for the microwave keypad entry stage.
package microwave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int unsigned MAX_DIGITS       = 4;
  localparam int unsigned BCD_W            = 4;
  localparam int unsigned SECONDS_PER_MIN  = 60;
  localparam int unsigned MAX_COOK_SECONDS = 6039;
  localparam int unsigned DISP_W           = MAX_DIGITS * BCD_W;
  localparam int unsigned DUR_W            = 16;
  localparam int unsigned CNT_W            = 3;
  localparam int unsigned HEAT_W           = 2;

endpackage

// File: rtl/time_entry_if.sv
// Key inputs and committed-value outputs between the board top and time_entry.
interface time_entry_if;
  import microwave_pkg::*;

  logic [BCD_W-1:0]  iDigit;
  logic              iDigitKey;
  logic              iEnterKey;
  logic              iClearKey;
  logic [HEAT_W-1:0] iHeatSel;
  logic              iBusy;
  logic [DUR_W-1:0]  oDuration;
  logic [HEAT_W-1:0] oHeatingLevel;
  logic              oLoadDuration;
  logic              oLoadHeat;
  logic [DISP_W-1:0] oDisplayBCD;
  logic [CNT_W-1:0]  oDigitCount;
  logic              oError;

  modport slave (
    input  iDigit, iDigitKey, iEnterKey, iClearKey, iHeatSel, iBusy,
    output oDuration, oHeatingLevel, oLoadDuration, oLoadHeat,
           oDisplayBCD, oDigitCount, oError
  );

  modport master (
    output iDigit, iDigitKey, iEnterKey, iClearKey, iHeatSel, iBusy,
    input  oDuration, oHeatingLevel, oLoadDuration, oLoadHeat,
           oDisplayBCD, oDigitCount, oError
  );

endinterface

// File: rtl/key_edge.sv
// Rising-edge detector for a debounced key level; history tracks the level during
// reset so a key held through reset never produces an edge.
module key_edge (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise_c
);

  logic level_q;

  always_ff @(posedge clock) begin
    if (reset) level_q <= level;
    else       level_q <= level;
  end

  assign rise_c = level & ~level_q & ~reset;

endmodule

// File: rtl/time_entry.sv
// Keypad MM:SS entry buffer with commit to binary seconds and one-cycle load strobes.
module time_entry #(
  parameter int unsigned MAX_DIGITS = 4
) (
  input logic         clock,
  input logic         reset,
  time_entry_if.slave bus
);
  import microwave_pkg::*;

  localparam logic [BCD_W-1:0] DIGIT_MAX = BCD_W'(9);
  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [DUR_W-1:0] SEC_M1    = DUR_W'(SECONDS_PER_MIN * 10);
  localparam logic [DUR_W-1:0] SEC_M0    = DUR_W'(SECONDS_PER_MIN);
  localparam logic [DUR_W-1:0] SEC_S1    = DUR_W'(10);

  logic              digit_rise_c;
  logic              enter_rise_c;
  logic              clear_rise_c;
  state_t            state;
  logic [DISP_W-1:0] buffer;
  logic [CNT_W-1:0]  count;
  logic [DUR_W-1:0]  seconds_c;

  key_edge u_digit_edge (.clock(clock), .reset(reset), .level(bus.iDigitKey), .rise_c(digit_rise_c));
  key_edge u_enter_edge (.clock(clock), .reset(reset), .level(bus.iEnterKey), .rise_c(enter_rise_c));
  key_edge u_clear_edge (.clock(clock), .reset(reset), .level(bus.iClearKey), .rise_c(clear_rise_c));

  // Seconds digits above 5 are legal, so this is a plain weighted sum.
  assign seconds_c = DUR_W'(buffer[15:12]) * SEC_M1
                   + DUR_W'(buffer[11:8])  * SEC_M0
                   + DUR_W'(buffer[7:4])   * SEC_S1
                   + DUR_W'(buffer[3:0]);

  assign bus.oDisplayBCD = buffer;
  assign bus.oDigitCount = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= ST_IDLE;
      buffer            <= '0;
      count             <= '0;
      bus.oDuration     <= '0;
      bus.oHeatingLevel <= '0;
      bus.oLoadDuration <= 1'b0;
      bus.oLoadHeat     <= 1'b0;
      bus.oError        <= 1'b0;
    end else begin
      bus.oLoadDuration <= 1'b0;
      bus.oLoadHeat     <= 1'b0;
      bus.oError        <= 1'b0;
      if (state == ST_COMMIT) begin
        state <= ST_HOLD;
      end else if (!bus.iBusy) begin
        // Priority: clear > enter > digit; losers are silently dropped.
        if (clear_rise_c) begin
          buffer <= '0;
          count  <= '0;
          state  <= ST_IDLE;
        end else if (enter_rise_c) begin
          if (state == ST_HOLD || (state == ST_ENTRY && buffer != '0)) begin
            bus.oDuration     <= seconds_c;
            bus.oHeatingLevel <= bus.iHeatSel;
            bus.oLoadDuration <= 1'b1;
            bus.oLoadHeat     <= 1'b1;
            state             <= ST_COMMIT;
          end else begin
            bus.oError <= 1'b1;
          end
        end else if (digit_rise_c) begin
          if (bus.iDigit > DIGIT_MAX) begin
            bus.oError <= 1'b1;
          end else if (state == ST_HOLD) begin
            buffer <= {{(DISP_W-BCD_W){1'b0}}, bus.iDigit};
            count  <= CNT_W'(1);
            state  <= ST_ENTRY;
          end else if (count < COUNT_MAX) begin
            buffer <= {buffer[DISP_W-BCD_W-1:0], bus.iDigit};
            count  <= count + CNT_W'(1);
            state  <= ST_ENTRY;
          end else begin
            bus.oError <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/time_entry.md
# time_entry

Keypad-style cook-time and heat-level entry stage that sits directly upstream of the microwave datapath. It collects decimal digit presses into a 4-digit MM:SS buffer that shifts in from the right, like a microwave keypad. On Enter it converts the buffer to a binary seconds count and issues single-cycle load strobes that drive the datapath's duration and heat-level registers. All key inputs are debounced, active-high levels supplied by the board top level.

## Interface
Parameters:
- MAX_DIGITS, 4, digit capacity of the entry buffer (M1 M0 S1 S0)

Ports:
- clock  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- iDigit  in  4  BCD digit value, sampled on iDigitKey rising edge
- iDigitKey  in  1  digit key level
- iEnterKey  in  1  Enter/commit key level
- iClearKey  in  1  clear key level
- iHeatSel  in  2  heating level from switches, captured at commit
- iBusy  in  1  high while control FSM is cooking; blocks all entry
- oDuration  out  16  committed cook time in binary seconds (0..6039)
- oHeatingLevel  out  2  committed heating level
- oLoadDuration  out  1  one-cycle strobe to datapath loadDuration
- oLoadHeat  out  1  one-cycle strobe to datapath loadHeat, coincident with oLoadDuration
- oDisplayBCD  out  16  live buffer {M1,M0,S1,S0} for 7-segment display
- oDigitCount  out  3  digits currently entered (0..4)
- oError  out  1  one-cycle pulse on a rejected key

## Operation
- Rising-edge detect on the three key levels. Each edge is valid for one cycle only.
- Priority within a cycle: iBusy > clear > enter > digit. Lower-priority edges in the same cycle are dropped, with no error.
- iBusy=1: all edges ignored, no error, state and buffer frozen.
- States: IDLE (count=0), ENTRY (1..4 digits), COMMIT (strobe cycle), HOLD (value committed).
- IDLE and ENTRY, digit edge:
  - iDigit>9: oError, no change.
  - count<4: buffer <= {buffer[11:0], iDigit}, count+1, state ENTRY.
  - count==4: oError, no change. No wrap; the oldest digit is never discarded.
- Leading zeros are accepted and counted.
- Clear edge (any state except COMMIT): buffer=0, count=0, IDLE. oDuration and oHeatingLevel are not changed.
- Enter edge:
  - In IDLE, or in ENTRY with buffer value 0: oError, no change.
  - In ENTRY with non-zero buffer: go to COMMIT. oDuration <= (M1*10+M0)*60 + S1*10+S0 and oHeatingLevel <= iHeatSel, both registered.
- Seconds digits >59 are legal, e.g. 0:99 = 99 s. Maximum 99:99 = 6039 s. 13 bits are used; upper bits are zero.
- COMMIT: oLoadDuration=oLoadHeat=1 for exactly this cycle, then HOLD. Edges arriving in the COMMIT cycle are dropped.
- HOLD:
  - Buffer and display keep the committed digits.
  - Digit edge: buffer cleared, then the new digit is shifted in, count=1, ENTRY.
  - Enter edge: re-commit of the same value (COMMIT again).
  - Clear edge: IDLE.

## Timing
- Reset:
  - State IDLE, buffer 0, count 0.
  - oDuration 0, oHeatingLevel 0, all strobes and oError 0.
  - Edge-detect history registers are loaded with the current key levels, so a key held through reset produces no edge.
- Key level first sampled high at clock edge k: edge acted on at edge k. oDisplayBCD, oDigitCount and oError reflect it after edge k (1-cycle latency).
- Enter accepted at edge k: oDuration and oHeatingLevel valid after edge k. oLoadDuration and oLoadHeat are high between edges k and k+1, then held low.
- oError: exactly one cycle per rejected edge.
- Reset asserted mid-COMMIT: the strobe is cancelled from the next edge onward.
- iBusy rising in the same cycle as an Enter edge: Enter is dropped.

## Structure
- Shared package (microwave_pkg):
  - state encoding (IDLE, ENTRY, COMMIT, HOLD)
  - MAX_DIGITS
  - BCD digit width (4)
  - SECONDS_PER_MIN (60)
  - MAX_COOK_SECONDS (6039)
- Sub-module key_edge:
  - 1-bit rising-edge detector with reset preload
  - instantiated three times
- BCD-to-seconds conversion is combinational inside time_entry, using constant multiplies only.

## Test plan
- Reset, then digits 1,3,0 and Enter, iHeatSel=2 → oDisplayBCD 0x0130, oDigitCount 3, then oDuration=90 with a single-cycle oLoadDuration/oLoadHeat and oHeatingLevel=2.
- Digits 9,9,9,9,5 → fifth press gives a 1-cycle oError; buffer stays 0x9999; Enter gives oDuration=6039.
- Enter in IDLE, and Enter after digits 0,0 → oError each time, no strobe, oDuration unchanged.
- iBusy=1 with digit/Enter/Clear presses → no change, no strobe, no error. Lower iBusy, press 5 → buffer 0x0005.
- Same-cycle Clear+Enter after digits 4,5 → buffer cleared, IDLE, no strobe. Later, a digit press in HOLD after a commit restarts entry with count 1.
- Key held high through reset release → no edge and no buffer change. Reset asserted during the COMMIT cycle → strobe low on the following cycle, all outputs 0.
